// File: rtl/ecc_scrubber_5_if.sv
// Synchronous single-port memory bus shared between the scrubber (master)
// and the SECDED codeword array (slave).
interface ecc_scrubber_5_if #(
  parameter int AW = 4
);
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic [15:0]   mem_rdata;
  logic          mem_we;
  logic [15:0]   mem_wdata;

  modport master (
    output mem_addr,
    output mem_re,
    output mem_we,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_re,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/ecc_scrubber_5.sv
// Background SECDED scrubber: sweeps every codeword once per start, rewrites
// single-bit-correctable words re-encoded, and counts corrected/uncorrectable words.
module ecc_scrubber_5 #(
  parameter int AW    = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  ecc_scrubber_5_if.master mem,
  output logic [CNT_W-1:0] corr_count,
  output logic [CNT_W-1:0] uncorr_count,
  output logic [AW-1:0]    last_uncorr_addr
);

  typedef enum logic [2:0] {IDLE, RD, EVAL, WB, DONE} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] addr;
  logic [15:0]   wdata;

  logic [10:0] rd_d;
  logic [3:0]  rd_c;
  logic [3:0]  syn;
  logic        par_odd;
  logic [10:0] flip;
  logic [15:0] fixed_cw;
  logic        addr_last;

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [3:0] c;
    logic       p;
    c[0] = d[10] ^ d[9] ^ d[7] ^ d[6] ^ d[4] ^ d[2] ^ d[0];
    c[1] = d[10] ^ d[8] ^ d[7] ^ d[5] ^ d[4] ^ d[1] ^ d[0];
    c[2] = d[9]  ^ d[8] ^ d[7] ^ d[3] ^ d[2] ^ d[1] ^ d[0];
    c[3] = d[6]  ^ d[5] ^ d[4] ^ d[3] ^ d[2] ^ d[1] ^ d[0];
    p    = (^d) ^ (^c);
    return {p, c, d};
  endfunction

  always_comb begin
    rd_d     = mem.mem_rdata[10:0];
    rd_c     = mem.mem_rdata[14:11];
    syn      = encode(rd_d) >> 11;
    syn      = syn ^ rd_c;
    par_odd  = ^mem.mem_rdata;
    flip     = '0;
    // Syndromes naming a check or parity bit leave the data alone.
    case (syn)
      4'd3:    flip[10] = 1'b1;
      4'd5:    flip[9]  = 1'b1;
      4'd6:    flip[8]  = 1'b1;
      4'd7:    flip[7]  = 1'b1;
      4'd9:    flip[6]  = 1'b1;
      4'd10:   flip[5]  = 1'b1;
      4'd11:   flip[4]  = 1'b1;
      4'd12:   flip[3]  = 1'b1;
      4'd13:   flip[2]  = 1'b1;
      4'd14:   flip[1]  = 1'b1;
      4'd15:   flip[0]  = 1'b1;
      default: flip     = '0;
    endcase
    fixed_cw  = encode(rd_d ^ flip);
    addr_last = (addr == '1);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = RD;
      RD:   state_nx = EVAL;
      EVAL: begin
        if (par_odd)        state_nx = WB;
        else if (addr_last) state_nx = DONE;
        else                state_nx = RD;
      end
      WB:   state_nx = addr_last ? DONE : RD;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      addr             <= '0;
      wdata            <= '0;
      corr_count       <= '0;
      uncorr_count     <= '0;
      last_uncorr_addr <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            addr             <= '0;
            corr_count       <= '0;
            uncorr_count     <= '0;
            last_uncorr_addr <= '0;
          end
        end
        EVAL: begin
          wdata <= fixed_cw;
          if (par_odd) begin
            if (corr_count != '1) corr_count <= corr_count + CNT_W'(1);
          end else begin
            if (syn != 4'd0) begin
              if (uncorr_count != '1) uncorr_count <= uncorr_count + CNT_W'(1);
              last_uncorr_addr <= addr;
            end
            if (!addr_last) addr <= addr + AW'(1);
          end
        end
        WB: begin
          if (!addr_last) addr <= addr + AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign mem.mem_re    = (state == RD);
  assign mem.mem_we    = (state == WB);
  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = wdata;

endmodule

// File: tb/tb_ecc_scrubber_5.sv
// Directed bench for ecc_scrubber_5: single-word sweep vectors, mid-sweep reset,
// and counter saturation on a narrow-counter instance.
module tb_ecc_scrubber_5;

  logic       clock;
  logic       reset;
  logic       start_a, start_b;
  logic       busy_a, done_a, busy_b, done_b;
  logic [7:0] corr_a, uncorr_a;
  logic [1:0] corr_b, uncorr_b;
  logic [3:0] last_a, last_b;

  logic        ld_en_a, ld_en_b;
  logic [3:0]  ld_addr;
  logic [15:0] ld_data;
  logic [15:0] mem_a [16];
  logic [15:0] mem_b [16];

  int total = 0;
  int bad   = 0;

  ecc_scrubber_5_if #(.AW(4)) ma ();
  ecc_scrubber_5_if #(.AW(4)) mb ();

  ecc_scrubber_5 #(.AW(4), .CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
    .mem(ma), .corr_count(corr_a), .uncorr_count(uncorr_a), .last_uncorr_addr(last_a)
  );

  ecc_scrubber_5 #(.AW(4), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .mem(mb), .corr_count(corr_b), .uncorr_count(uncorr_b), .last_uncorr_addr(last_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ld_en_a) mem_a[ld_addr] <= ld_data;
    else if (ma.mem_we) mem_a[ma.mem_addr] <= ma.mem_wdata;
    if (ma.mem_re) ma.mem_rdata <= mem_a[ma.mem_addr];
    if (ld_en_b) mem_b[ld_addr] <= ld_data;
    else if (mb.mem_we) mem_b[mb.mem_addr] <= mb.mem_wdata;
    if (mb.mem_re) mb.mem_rdata <= mem_b[mb.mem_addr];
  end

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] word;
    int          writes;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    int          corr;
    int          uncorr;
    logic [3:0]  last;
    int          done_cyc;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill(input bit sel_b, input logic [15:0] mask, input logic [15:0] word);
    for (int i = 0; i < 16; i++) begin
      ld_addr = 4'(i);
      ld_data = mask[i] ? word : 16'h0000;
      ld_en_a = !sel_b;
      ld_en_b = sel_b;
      @(posedge clock); #1;
    end
    ld_en_a = 1'b0;
    ld_en_b = 1'b0;
  endtask

  // Called #1 into a cycle; that cycle is cycle 0 of the sweep.
  task automatic run_sweep_a(output int done_cyc, output int nwr, output logic [3:0] waddr,
                             output logic [15:0] wdata, output int overlap,
                             output int busy_bad, output int first_rd_ok);
    done_cyc = -1; nwr = 0; waddr = '0; wdata = '0; overlap = 0; busy_bad = 0; first_rd_ok = 0;
    start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      if (cyc == 1) first_rd_ok = (ma.mem_re && ma.mem_addr == 4'd0) ? 1 : 0;
      if (ma.mem_re && ma.mem_we) overlap++;
      if (ma.mem_we) begin
        nwr++;
        waddr = ma.mem_addr;
        wdata = ma.mem_wdata;
      end
      if (!busy_a) busy_bad++;
      if (done_a) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    int          dc, nw, ov, bb, fr, strobes, found;
    logic [3:0]  wa;
    logic [15:0] wd;
    string       nm;

    vecs[0] = '{4'd0,  16'h0000, 0, 4'd0,  16'h0000, 0, 0, 4'd0,  33};
    vecs[1] = '{4'd5,  16'hF800, 1, 4'd5,  16'hF801, 1, 0, 4'd0,  34};
    vecs[2] = '{4'd9,  16'h0003, 0, 4'd0,  16'h0000, 0, 1, 4'd9,  33};
    vecs[3] = '{4'd2,  16'h8000, 1, 4'd2,  16'h0000, 1, 0, 4'd0,  34};
    vecs[4] = '{4'd15, 16'hFC01, 1, 4'd15, 16'hF801, 1, 0, 4'd0,  34};
    vecs[5] = '{4'd0,  16'h2000, 1, 4'd0,  16'h0000, 1, 0, 4'd0,  34};
    vecs[6] = '{4'd7,  16'h0081, 0, 4'd0,  16'h0000, 0, 1, 4'd7,  33};
    vecs[7] = '{4'd3,  16'hF801, 0, 4'd0,  16'h0000, 0, 0, 4'd0,  33};
    vecs[8] = '{4'd10, 16'hFFDF, 1, 4'd10, 16'hFFFF, 1, 0, 4'd0,  34};
    vecs[9] = '{4'd15, 16'h0081, 0, 4'd0,  16'h0000, 0, 1, 4'd15, 33};

    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    ld_en_a = 1'b0; ld_en_b = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst busy_a", 32'(busy_a), 0);
    chk("rst done_a", 32'(done_a), 0);
    chk("rst re_a", 32'(ma.mem_re), 0);
    chk("rst we_a", 32'(ma.mem_we), 0);
    chk("rst addr_a", 32'(ma.mem_addr), 0);
    chk("rst wdata_a", 32'(ma.mem_wdata), 0);
    chk("rst corr_a", 32'(corr_a), 0);
    chk("rst uncorr_a", 32'(uncorr_a), 0);
    chk("rst last_a", 32'(last_a), 0);
    chk("rst busy_b", 32'(busy_b), 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      fill(1'b0, 16'(1) << vecs[i].addr, vecs[i].word);
      run_sweep_a(dc, nw, wa, wd, ov, bb, fr);
      nm = $sformatf("v%0d", i);
      chk({nm, " done_cyc"}, 32'(dc), 32'(vecs[i].done_cyc));
      chk({nm, " writes"}, 32'(nw), 32'(vecs[i].writes));
      if (vecs[i].writes != 0) begin
        chk({nm, " waddr"}, 32'(wa), 32'(vecs[i].waddr));
        chk({nm, " wdata"}, 32'(wd), 32'(vecs[i].wdata));
      end
      chk({nm, " re_we_overlap"}, 32'(ov), 0);
      chk({nm, " busy_gap"}, 32'(bb), 0);
      chk({nm, " first_rd_addr0"}, 32'(fr), 1);
      @(posedge clock); #1;
      chk({nm, " busy_after"}, 32'(busy_a), 0);
      @(posedge clock); #1;
      chk({nm, " corr"}, 32'(corr_a), 32'(vecs[i].corr));
      chk({nm, " uncorr"}, 32'(uncorr_a), 32'(vecs[i].uncorr));
      chk({nm, " last"}, 32'(last_a), 32'(vecs[i].last));
    end

    // Reset in the cycle after the write-back of addr 3.
    fill(1'b0, 16'h0008, 16'hF800);
    start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    found = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (ma.mem_we) begin
        found = cyc;
        chk("rstmid wb_addr", 32'(ma.mem_addr), 3);
        chk("rstmid wb_data", 32'(ma.mem_wdata), 32'h0000F801);
        break;
      end
      @(posedge clock); #1;
    end
    chk("rstmid wb_cycle", 32'(found), 9);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rstmid busy", 32'(busy_a), 0);
    chk("rstmid done", 32'(done_a), 0);
    chk("rstmid re", 32'(ma.mem_re), 0);
    chk("rstmid we", 32'(ma.mem_we), 0);
    chk("rstmid addr", 32'(ma.mem_addr), 0);
    chk("rstmid wdata", 32'(ma.mem_wdata), 0);
    chk("rstmid corr", 32'(corr_a), 0);
    reset = 1'b0;
    strobes = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      if (ma.mem_re || ma.mem_we || busy_a) strobes++;
    end
    chk("rstmid quiet", 32'(strobes), 0);
    run_sweep_a(dc, nw, wa, wd, ov, bb, fr);
    chk("rstmid resweep done_cyc", 32'(dc), 33);
    chk("rstmid resweep writes", 32'(nw), 0);
    chk("rstmid resweep addr0", 32'(fr), 1);

    // Narrow counters: five uncorrectable words, plus a start while busy.
    fill(1'b1, 16'h2852, 16'h0003);
    start_b = 1'b1;
    @(posedge clock); #1;
    start_b = 1'b0;
    dc = -1; nw = 0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      start_b = (cyc == 10) ? 1'b1 : 1'b0;
      if (mb.mem_we) nw++;
      if (done_b) begin
        dc = cyc;
        break;
      end
      @(posedge clock); #1;
    end
    start_b = 1'b0;
    chk("sat done_cyc", 32'(dc), 33);
    chk("sat writes", 32'(nw), 0);
    @(posedge clock); #1;
    chk("sat busy_after", 32'(busy_b), 0);
    chk("sat uncorr", 32'(uncorr_b), 3);
    chk("sat corr", 32'(corr_b), 0);
    chk("sat last", 32'(last_b), 13);
    repeat (3) @(posedge clock);
    #1;
    chk("sat hold uncorr", 32'(uncorr_b), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ecc_scrubber_5.md
# ecc_scrubber_5

Background scrubber for the 16-bit SECDED codeword store behind the 11-bit ECC memory. On `start` it walks every address, reads the stored codeword, and decodes it with the same Hamming(15,11) check equations plus overall parity used by the ECC encoder. It rewrites single-bit-correctable words with a freshly encoded codeword, counts corrected and uncorrectable words, and reports completion. It sits beside the memory array as a second master on a simple synchronous read/write port.

## Interface
- `AW`, 4: address width; sweep covers `2**AW` words.
- `CNT_W`, 8: width of error counters.

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` through DONE.
- `done`  out  1  one-cycle pulse at end of sweep.
- `mem_addr`  out  AW  read/write address.
- `mem_re`  out  1  read strobe.
- `mem_rdata`  in  16  codeword; valid the cycle after `mem_re`.
- `mem_we`  out  1  write strobe.
- `mem_wdata`  out  16  re-encoded codeword.
- `corr_count`  out  CNT_W  words corrected this sweep; saturating.
- `uncorr_count`  out  CNT_W  uncorrectable words this sweep; saturating.
- `last_uncorr_addr`  out  AW  address of the most recent uncorrectable word.

## Operation
- Codeword layout: `[15]` = p, `[14:11]` = c[3:0], `[10:0]` = d[10:0].
- Check bits:
  - c0 = d10^d9^d7^d6^d4^d2^d0
  - c1 = d10^d8^d7^d5^d4^d1^d0
  - c2 = d9^d8^d7^d3^d2^d1^d0
  - c3 = d6^d5^d4^d3^d2^d1^d0
  - p = XOR of d and c.
- Syndrome s[i] = recomputed c_i ^ stored c_i. Overall parity q = XOR of all 16 read bits.
- Classification:
  - s=0, q=0: clean.
  - q=1: correctable. Flip data bit per s: 3→d10, 5→d9, 6→d8, 7→d7, 9→d6, 10→d5, 11→d4, 12→d3, 13→d2, 14→d1, 15→d0. For s = 0, 1, 2, 4 or 8 the data is unchanged; only check/parity are regenerated.
  - s≠0, q=0: uncorrectable.
- Correctable words: write back `{p, c, d_corrected}` fully re-encoded from the corrected data, and increment `corr_count`.
- Uncorrectable words: no write. Increment `uncorr_count` and load `last_uncorr_addr`.
- Counters and `last_uncorr_addr` clear on an accepted `start` and hold their values after `done` until the next accepted `start`.
- FSM states:
  - IDLE: on `start`, clear counters, set addr = 0, go to RD.
  - RD: `mem_re` = 1, go to EVAL.
  - EVAL: decode `mem_rdata` and register `mem_wdata`. Correctable goes to WB. Otherwise, if addr = max go to DONE, else addr+1 and go to RD.
  - WB: `mem_we` = 1. If addr = max go to DONE, else addr+1 and go to RD.
  - DONE: `done` = 1 for one cycle, go to IDLE.
- `start` outside IDLE is ignored.

## Timing
- Reset values: state IDLE; `busy`, `done`, `mem_re`, `mem_we` = 0; `mem_addr`, `mem_wdata`, both counters, `last_uncorr_addr` = 0.
- Reset mid-sweep takes effect at the next edge. The sweep is abandoned with no further strobes; any write is either completed whole in WB or not issued.
- Per-word latency: 2 cycles clean or uncorrectable, 3 cycles corrected.
- `mem_addr` is stable across RD, EVAL and WB of the same word.
- `mem_re` and `mem_we` are never high together.
- Address wraps max→0 only via DONE; no second pass.
- Counters saturate at `2**CNT_W-1`. At saturation `last_uncorr_addr` still updates.
- Sweep of N words with k corrections, `start` at cycle 0:
  - `busy` is high during cycles 1 through 2N+k+1.
  - `done` pulses at cycle 2N+k+1.
  - `busy` is low from cycle 2N+k+2.

## Test plan
- All 16 words = 0x0000, `start` → no `mem_we`; `done` at cycle 33; both counts 0.
- addr 5 = 0xF800 (0xF801 with d0 flipped), others 0 → exactly one write, addr 5, `mem_wdata` = 0xF801; `corr_count` = 1; `done` at cycle 34.
- addr 9 = 0x0003 (s = 1, q = 0) → no write; `uncorr_count` = 1; `last_uncorr_addr` = 9.
- addr 2 = 0x8000 (parity bit only) → write 0x0000 to addr 2; `corr_count` = 1.
- Reset asserted in the cycle after the WB of addr 3 during a sweep → next cycle all outputs are at reset values; no further `mem_re`/`mem_we`; a new `start` sweeps from addr 0.
- `CNT_W` = 2 with 5 uncorrectable words → `uncorr_count` = 3; `last_uncorr_addr` = highest bad address; `start` while busy has no effect.
